// File: rtl/level_sequencer_if.sv
// Signal bundle between the game-state FSM (master) and the level sequencer (slave).
// Handshake: a selection is offered while level_valid=1 and level_out stays stable
// until the edge where level_ack is sampled high; level_ack is ignored when level_valid=0.
interface level_sequencer_if #(
  parameter int SIZE_BITS = 4
);
  logic                 start_game;
  logic                 level_done;
  logic [SIZE_BITS-1:0] rand_in;
  logic [SIZE_BITS-1:0] level_out;
  logic                 level_valid;
  logic                 level_ack;
  logic                 busy;
  logic                 maze_active;
  logic                 game_complete;

  modport slave (
    input  start_game, level_done, rand_in, level_ack,
    output level_out, level_valid, busy, maze_active, game_complete
  );

  modport master (
    output start_game, level_done, rand_in, level_ack,
    input  level_out, level_valid, busy, maze_active, game_complete
  );
endinterface

// File: rtl/level_sequencer.sv
// Picks the next unplayed level: random draws first, deterministic ascending scan
// after MAX_RETRY rejections, and the maze level once every normal level is played.
module level_sequencer #(
  parameter int SIZE_BITS  = 4,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 6,
  parameter int MAZE_LEVEL = 7,
  parameter int MAX_RETRY  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  level_sequencer_if.slave           bus,
  output logic [2:0]                 state_dbg,
  output logic [MAX_VAL-MIN_VAL:0]   played_dbg
);

  localparam int NUM_LEVELS = MAX_VAL - MIN_VAL + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SIZE_BITS-1:0]   level_out_q, level_out_d;
  logic                   level_valid_q, level_valid_d;
  logic [NUM_LEVELS-1:0]  mask_q, mask_d;
  logic [3:0]             retry_q, retry_d;
  logic [SIZE_BITS-1:0]   scan_q, scan_d;
  logic                   maze_q, maze_d;
  logic                   gc_q, gc_d;

  logic cand_in_range;
  logic cand_ok;
  logic all_played;

  // Index-to-mask lookups are written as loops so indices outside the normal range
  // simply miss instead of addressing past the mask.
  function automatic logic is_played(input logic [NUM_LEVELS-1:0] mask,
                                     input logic [SIZE_BITS-1:0]  idx);
    is_played = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (int'(idx) == MIN_VAL + i) is_played = mask[i];
    end
  endfunction

  function automatic logic [NUM_LEVELS-1:0] level_bit(input logic [SIZE_BITS-1:0] idx);
    level_bit = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (int'(idx) == MIN_VAL + i) level_bit[i] = 1'b1;
    end
  endfunction

  assign cand_in_range = (int'(bus.rand_in) >= MIN_VAL) && (int'(bus.rand_in) <= MAX_VAL);
  assign cand_ok       = cand_in_range && !is_played(mask_q, bus.rand_in);
  assign all_played    = &mask_q;

  always_comb begin
    state_d       = state_q;
    level_out_d   = level_out_q;
    level_valid_d = level_valid_q;
    mask_d        = mask_q;
    retry_d       = retry_q;
    scan_d        = scan_q;
    maze_d        = maze_q;
    gc_d          = gc_q;

    // start_game pre-empts every state, dropping any pending unacked selection.
    if (bus.start_game) begin
      mask_d        = '0;
      maze_d        = 1'b0;
      gc_d          = 1'b0;
      level_valid_d = 1'b0;
      retry_d       = '0;
      state_d       = ST_DRAW;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.level_done) begin
            if (maze_q) begin
              gc_d    = 1'b1;
              state_d = ST_DONE;
            end else if (all_played) begin
              level_out_d   = SIZE_BITS'(MAZE_LEVEL);
              level_valid_d = 1'b1;
              state_d       = ST_ISSUE;
            end else begin
              state_d = ST_DRAW;
            end
          end
        end
        ST_DRAW: begin
          if (cand_ok) begin
            level_out_d   = bus.rand_in;
            level_valid_d = 1'b1;
            retry_d       = '0;
            state_d       = ST_ISSUE;
          end else if (int'(retry_q) + 1 >= MAX_RETRY) begin
            retry_d = '0;
            scan_d  = SIZE_BITS'(MIN_VAL);
            state_d = ST_SCAN;
          end else begin
            retry_d = retry_q + 4'd1;
          end
        end
        ST_SCAN: begin
          if (!is_played(mask_q, scan_q)) begin
            level_out_d   = scan_q;
            level_valid_d = 1'b1;
            state_d       = ST_ISSUE;
          end else begin
            scan_d = scan_q + SIZE_BITS'(1);
          end
        end
        ST_ISSUE: begin
          if (bus.level_ack && level_valid_q) begin
            if (int'(level_out_q) == MAZE_LEVEL) maze_d = 1'b1;
            else                                 mask_d = mask_q | level_bit(level_out_q);
            level_valid_d = 1'b0;
            state_d       = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      level_out_q   <= '0;
      level_valid_q <= 1'b0;
      mask_q        <= '0;
      retry_q       <= '0;
      scan_q        <= SIZE_BITS'(MIN_VAL);
      maze_q        <= 1'b0;
      gc_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_out_q   <= level_out_d;
      level_valid_q <= level_valid_d;
      mask_q        <= mask_d;
      retry_q       <= retry_d;
      scan_q        <= scan_d;
      maze_q        <= maze_d;
      gc_q          <= gc_d;
    end
  end

  assign bus.level_out     = level_out_q;
  assign bus.level_valid   = level_valid_q;
  assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.maze_active   = maze_q;
  assign bus.game_complete = gc_q;
  assign state_dbg         = state_q;
  assign played_dbg        = mask_q;

endmodule
